// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter and data_mem.
package dmem_pkg;

    localparam int AW_DEF  = 8;
    localparam int DW_DEF  = 8;
    localparam int CTW_DEF = 16;

    // Memory ownership: shared round-robin, or held exclusively by the host.
    typedef enum logic {
        FREE      = 1'b0,
        HOST_LOCK = 1'b1
    } own_t;

    // Requester ids as stored in the last-winner register.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker. A tie goes to the requester that did not win
// most recently; mask0 removes requester 0 from contention (host lock).
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_win,
    input  logic       mask0,
    output logic [1:0] gnt
);

    logic [1:0] eff;

    // One-hot grant from the effective request vector and the previous winner.
    always_comb begin
        eff = {req[1], req[0] & ~mask0};
        gnt = 2'b00;
        case (eff)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_win ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data_mem between the core (requester 0) and the
// host/loader (requester 1). Same-cycle grant, one-cycle registered read
// return, optional host ownership lock, saturating core stall counter.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int CTW = CTW_DEF
) (
    input  logic           CLK,
    input  logic           start,
    input  logic           req0,
    input  logic           req1,
    input  logic           we0,
    input  logic           we1,
    input  logic [AW-1:0]  addr0,
    input  logic [AW-1:0]  addr1,
    input  logic [DW-1:0]  wdata0,
    input  logic [DW-1:0]  wdata1,
    input  logic           lock1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           rvalid0,
    output logic           rvalid1,
    output logic [DW-1:0]  rdata0,
    output logic [DW-1:0]  rdata1,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_wen,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    output logic [CTW-1:0] stall_ct
);

    own_t       state;
    own_t       state_nxt;
    logic       last_win;
    logic [1:0] req_q;
    logic [1:0] gnt;

    // While start is high nobody is granted, so no access or rvalid can
    // be launched during reset.
    assign req_q = {req1, req0} & {2{~start}};

    rr_pick2 u_pick (
        .req      (req_q),
        .last_win (last_win),
        .mask0    (state == HOST_LOCK),
        .gnt      (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Route the winner onto the memory port; idle port parks at address 0.
    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_addr  = addr0;
            mem_wen   = we0;
            mem_wdata = wdata0;
        end else if (gnt[1]) begin
            mem_addr  = addr1;
            mem_wen   = we1;
            mem_wdata = wdata1;
        end
    end

    // Ownership next state: lock on a locked host grant, release whenever
    // lock1 drops (the grant in the releasing cycle is still served).
    always_comb begin
        state_nxt = state;
        case (state)
            FREE:      if (gnt[1] & lock1) state_nxt = HOST_LOCK;
            HOST_LOCK: if (~lock1)         state_nxt = FREE;
            default:   state_nxt = FREE;
        endcase
    end

    // Ownership state register.
    always_ff @(posedge CLK) begin
        if (start) state <= FREE;
        else       state <= state_nxt;
    end

    // Remember who won last; reset to host so the core takes the first tie.
    always_ff @(posedge CLK) begin
        if (start)       last_win <= REQ_HOST;
        else if (gnt[0]) last_win <= REQ_CORE;
        else if (gnt[1]) last_win <= REQ_HOST;
    end

    // Core read return: capture on a granted read, pulse rvalid for one cycle.
    always_ff @(posedge CLK) begin
        if (start) begin
            rvalid0 <= 1'b0;
            rdata0  <= '0;
        end else begin
            rvalid0 <= gnt[0] & ~we0;
            if (gnt[0] & ~we0) rdata0 <= mem_rdata;
        end
    end

    // Host read return, same scheme as the core side.
    always_ff @(posedge CLK) begin
        if (start) begin
            rvalid1 <= 1'b0;
            rdata1  <= '0;
        end else begin
            rvalid1 <= gnt[1] & ~we1;
            if (gnt[1] & ~we1) rdata1 <= mem_rdata;
        end
    end

    // Count cycles where the core asks but is not served; stick at all-ones.
    always_ff @(posedge CLK) begin
        if (start)
            stall_ct <= '0;
        else if (req0 & ~gnt[0] & ~(&stall_ct))
            stall_ct <= stall_ct + CTW'(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port `data_mem`. It shares that memory between the processor core (requester 0: load/store path) and a host/loader port (requester 1: bench preload and result readback). The arbiter uses round-robin priority with an optional ownership lock for atomic multi-byte host transfers. It returns registered read data with a valid strobe, and it counts core stall cycles. It sits between the `TopLevel` datapath and `data_mem`, replacing the direct `ReadA`/`MEM_WRITE` hookup.

## Interface
- `AW`, 8: address width, byte-addressed.
- `DW`, 8: data width.
- `CTW`, 16: width of the stall counter.

- `CLK`  in  1  clock; all state updates on posedge.
- `start`  in  1  reset; synchronous, active-high.
- `req0`, `req1`  in  1  access request from core / host.
- `we0`, `we1`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr0`, `addr1`  in  AW  access address.
- `wdata0`, `wdata1`  in  DW  write data.
- `lock1`  in  1  host requests to keep ownership after the current access.
- `gnt0`, `gnt1`  out  1  access accepted this cycle; combinational from state and `req`.
- `rvalid0`, `rvalid1`  out  1  read data valid; one-cycle pulse.
- `rdata0`, `rdata1`  out  DW  registered read data.
- `mem_addr`  out  AW  to `data_mem` `DataAddress`.
- `mem_wen`  out  1  to `data_mem` `WriteMem`.
- `mem_wdata`  out  DW  to `data_mem` `DataIn`.
- `mem_rdata`  in  DW  from `data_mem` `DataOut`; combinational read.
- `stall_ct`  out  CTW  number of cycles with `req0 & ~gnt0`; saturating.

## Operation
- Ownership FSM states:
  - `FREE`: round-robin between requesters.
  - `HOST_LOCK`: requester 1 owns the memory exclusively.
- Arbitration in `FREE`:
  - Only one requester asserts `req`: that requester is granted.
  - Both assert `req`: grant goes to the requester that did not win most recently.
  - `last_win` register updates on every grant; reset value 1, so the core wins the first tie.
- Transitions:
  - `FREE` → `HOST_LOCK` when `gnt1 & lock1`.
  - `HOST_LOCK` → `FREE` on any cycle with `~lock1`, whether or not `req1` is asserted; a grant in that cycle is still served.
- `HOST_LOCK` behaviour:
  - `gnt0` = 0.
  - `gnt1` = `req1`.
  - Core requests stall and count toward `stall_ct`.
- Exactly one grant per cycle; `gnt0 & gnt1` is never 1.
- Memory port muxing:
  - The granted requester's `addr`/`wdata` drive `mem_addr`/`mem_wdata`.
  - `mem_wen` = `gnt & we` of the winner.
  - With no grant: `mem_addr` = 0 and `mem_wen` = 0.
- Read return:
  - On a granted read, `mem_rdata` is captured into that requester's `rdata` register at the next posedge.
  - The corresponding `rvalid` is 1 for exactly that following cycle.
  - `rdata` holds its value until the next read by the same requester.
- Granted write: the memory is updated at the posedge ending the grant cycle. No `rvalid` is produced.
- Requester obligations:
  - Keep `req`/`we`/`addr`/`wdata` stable until it sees `gnt`.
  - It may drop `req` before being granted; no side effect.
- `stall_ct` increments by 1 in each cycle with `req0 & ~gnt0`, and sticks at all-ones.

## Timing
- Grant is same-cycle combinational. Read latency is 1 cycle from grant to `rvalid`.
- Throughput: one access per cycle. Back-to-back grants to the same requester are allowed when the other requester is idle.
- Read-after-write to the same address in consecutive grants returns the new data, because `data_mem` writes at the posedge and reads combinationally.
- `start` = 1 at a posedge; the following cycle shows:
  - FSM = `FREE`, `last_win` = 1.
  - `rvalid0`/`rvalid1` = 0, `rdata0`/`rdata1` = 0, `stall_ct` = 0.
  - `gnt0`/`gnt1`/`mem_wen` forced 0 while `start` is high.
- Reset mid-lock or mid-read: the lock is dropped and a pending `rvalid` is suppressed.

## Structure
- Package `dmem_pkg`: `typedef enum logic {FREE, HOST_LOCK} own_t`, plus the `AW`/`DW` default constants shared with `data_mem`.
- Sub-module `rr_pick2`: a combinational 2-way round-robin picker with inputs `req[1:0]`, `last_win` and `mask0`, producing one-hot `gnt[1:0]`.
- Everything else is flat in `dmem_arbiter`.

## Test plan
- Reset, then `req0` only: read addr 0x10 with the memory preloaded to 0xA5 → `gnt0` = 1 the same cycle; `rvalid0` = 1 and `rdata0` = 0xA5 the next cycle; `stall_ct` = 0.
- Both requesting continuously for 4 cycles, no lock → grants alternate 0, 1, 0, 1; `stall_ct` = 2.
- `req1` with `lock1` = 1 for 3 writes (0x20–0x22 ← 0x01–0x03) while `req0` reads 0x20 → core stalls 3 cycles; the core is granted the cycle after `lock1` drops and receives 0x01; `stall_ct` = 3.
- Write then read the same address in consecutive cycles (host writes 0x7F ← 0x3C, core reads 0x7F) → `rdata0` = 0x3C.
- Assert `start` while in `HOST_LOCK` with a read just granted → next cycle FSM = `FREE`, `rvalid1` = 0, `stall_ct` = 0, core granted on its next request.
- Force `stall_ct` to all-ones via 2^CTW stalled cycles (bench with `CTW` = 4) → counter holds at 0xF.
